// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the alu_ctrl encodings agreed with ALU control decode, the default
// datapath width and the FSM state encoding of ex_alu_unit.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the multi-cycle shifter: shifts val_i by amt_i bits
// (amt_i never exceeds SHIFT_STEP) in the direction given by kind_i.
// Ports: val_i operand, amt_i step amount, kind_i alu_ctrl code
// (SLL/SRL/SRA), val_o shifted value. Purely combinational.
module alu_shift_step #(
  parameter  int XLEN       = 32,
  parameter  int SHIFT_STEP = 4,
  localparam int AW         = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0] val_i,
  input  logic [AW-1:0]   amt_i,
  input  logic [3:0]      kind_i,
  output logic [XLEN-1:0] val_o
);
  import alu_pkg::*;

  always_comb begin
    val_o = val_i;
    case (kind_i)
      ALU_SLL: val_o = val_i << amt_i;
      ALU_SRL: val_o = val_i >> amt_i;
      // The captured operand keeps its sign bit across steps, so an
      // arithmetic shift per step replicates the original sign.
      ALU_SRA: val_o = $signed(val_i) >>> amt_i;
      default: val_o = val_i;
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU. Single-cycle arithmetic/logic ops; shifts iterate
// SHIFT_STEP bits per cycle. Valid/ready on both sides, fully registered
// outputs, synchronous flush.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_ctrl/in_a/
// in_b/in_tag request side; out_valid/out_ready/out_result/out_zero/
// out_illegal/out_tag result side.
module ex_alu_unit #(
  parameter int XLEN       = alu_pkg::XLEN,
  parameter int SHIFT_STEP = 4,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  import alu_pkg::*;

  localparam int         AW    = $clog2(SHIFT_STEP + 1);
  localparam logic [5:0] STEP6 = 6'(SHIFT_STEP);

  alu_state_e       state_q, state_d;
  // Shift working set; kept apart from the output registers so the outputs
  // only change when a result is actually delivered.
  logic [XLEN-1:0]  sh_q, sh_d;
  logic [4:0]       rem_q, rem_d;
  logic [3:0]       kind_q, kind_d;
  logic [TAG_W-1:0] ptag_q, ptag_d;
  // Output registers
  logic [XLEN-1:0]  res_q, res_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept;
  logic [4:0]       in_shamt;
  logic             in_illegal;
  logic [XLEN-1:0]  alu_res;
  logic [AW-1:0]    step_amt;
  logic [4:0]       rem_next;
  logic [XLEN-1:0]  sh_next;

  assign in_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign in_shamt   = in_b[4:0];
  assign in_illegal = (in_ctrl > ALU_SLTU);

  // Single-cycle result. Illegal codes fall into the ADD default; shifts
  // only land here with a zero shift amount, which passes in_a through.
  always_comb begin
    alu_res = in_a + in_b;
    case (in_ctrl)
      ALU_SUB:  alu_res = in_a - in_b;
      ALU_AND:  alu_res = in_a & in_b;
      ALU_OR:   alu_res = in_a | in_b;
      ALU_XOR:  alu_res = in_a ^ in_b;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = in_a;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default:  alu_res = in_a + in_b;
    endcase
  end

  // Step this cycle is min(SHIFT_STEP, remaining).
  always_comb begin
    if ({1'b0, rem_q} >= STEP6) step_amt = AW'(SHIFT_STEP);
    else                        step_amt = AW'(rem_q);
    rem_next = rem_q - 5'(step_amt);
  end

  alu_shift_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shift_step (
    .val_i  (sh_q),
    .amt_i  (step_amt),
    .kind_i (kind_q),
    .val_o  (sh_next)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    kind_d  = kind_q;
    ptag_d  = ptag_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    tag_d   = tag_q;
    if (flush) begin
      // Kill whatever is pending; data outputs keep their last values.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (is_shift(in_ctrl) && (in_shamt != 5'd0)) begin
              state_d = ST_SHIFT;
              sh_d    = in_a;
              rem_d   = in_shamt;
              kind_d  = in_ctrl;
              ptag_d  = in_tag;
            end else begin
              state_d = ST_DONE;
              res_d   = alu_res;
              zero_d  = (alu_res == '0);
              ill_d   = in_illegal;
              tag_d   = in_tag;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sh_d  = sh_next;
          rem_d = rem_next;
          if (rem_next == 5'd0) begin
            state_d = ST_DONE;
            res_d   = sh_next;
            zero_d  = (sh_next == '0);
            ill_d   = 1'b0;
            tag_d   = ptag_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      kind_q  <= '0;
      ptag_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      kind_q  <= kind_d;
      ptag_q  <= ptag_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid   = (state_q == ST_DONE);
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_illegal = ill_q;
  assign out_tag     = tag_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit with hand-computed expected values.
module tb_ex_alu_unit;
  localparam int XLEN = 32, SHIFT_STEP = 4, TAG_W = 5;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0001, C_AND = 4'b0010,
                         C_OR  = 4'b0011, C_XOR = 4'b0100, C_SLL = 4'b0101,
                         C_SRL = 4'b0110, C_SRA = 4'b0111, C_SLT = 4'b1000,
                         C_SLTU = 4'b1001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_ctrl = '0;
  logic [XLEN-1:0]  in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [XLEN-1:0]  out_result;
  logic             out_zero, out_illegal;
  logic [TAG_W-1:0] out_tag;

  int n_chk = 0, n_err = 0;
  int lat;
  bit rdy_seen, vld_seen;

  logic [3:0]  vc[8];
  logic [31:0] va[8], vb[8], ve[8];

  ex_alu_unit #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    drive(c, a, b, t);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the cycle after the accept edge; lat counts that cycle as 1.
  task automatic wait_valid(output int l, output bit rs);
    l = 1; rs = 1'b0;
    while (!out_valid && l < 64) begin
      if (in_ready) rs = 1'b1;
      tick();
      l++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] r, input logic z,
                         input logic il, input logic [4:0] t);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, out_result, r);
    check({tag, "_zero"}, 32'(out_zero), 32'(z));
    check({tag, "_ill"}, 32'(out_illegal), 32'(il));
    check({tag, "_tag"}, 32'(out_tag), 32'(t));
  endtask

  initial begin
    vc = '{C_ADD, C_XOR, C_ADD, C_XOR, C_ADD, C_XOR, C_ADD, C_XOR};
    va = '{32'h1, 32'hFF00FF00, 32'hFFFFFFFF, 32'h12345678,
           32'h10000000, 32'hAAAAAAAA, 32'h100, 32'h0F};
    vb = '{32'h2, 32'h0F0F0F0F, 32'h1, 32'h12345678,
           32'h20000000, 32'h55555555, 32'h23, 32'hF0};
    ve = '{32'h3, 32'hF00FF00F, 32'h0, 32'h0,
           32'h30000000, 32'hFFFFFFFF, 32'h123, 32'hFF};

    // Reset state
    #2;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_res", out_result, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_vld2", 32'(out_valid), 32'd0);

    // Single-cycle ops, issued back-to-back
    issue(C_ADD, 32'h7FFFFFFF, 32'h1, 5'd3);   chk_res("add_ovf", 32'h80000000, 1'b0, 1'b0, 5'd3);
    issue(C_SUB, 32'd5, 32'd5, 5'd4);          chk_res("sub_zero", 32'h0, 1'b1, 1'b0, 5'd4);
    issue(C_SUB, 32'd3, 32'd5, 5'd5);          chk_res("sub_wrap", 32'hFFFFFFFE, 1'b0, 1'b0, 5'd5);
    issue(C_SLT, 32'hFFFFFFFF, 32'h1, 5'd6);   chk_res("slt", 32'h1, 1'b0, 1'b0, 5'd6);
    issue(C_SLTU, 32'hFFFFFFFF, 32'h1, 5'd7);  chk_res("sltu", 32'h0, 1'b1, 1'b0, 5'd7);
    issue(C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd8); chk_res("and", 32'hF000F000, 1'b0, 1'b0, 5'd8);
    issue(C_OR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd9); chk_res("or",  32'hFFF0FFF0, 1'b0, 1'b0, 5'd9);
    issue(C_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd10); chk_res("xor", 32'h0FF00FF0, 1'b0, 1'b0, 5'd10);
    issue(4'b1100, 32'd2, 32'd3, 5'd14);       chk_res("illegal", 32'h5, 1'b0, 1'b1, 5'd14);
    issue(C_SLL, 32'h1234, 32'h0, 5'd2);       chk_res("sll0", 32'h1234, 1'b0, 1'b0, 5'd2);
    tick();
    check("idle_vld", 32'(out_valid), 32'd0);

    // SRA by 31: 8 shift cycles, in_ready low throughout
    issue(C_SRA, 32'h80000000, 32'd31, 5'd7);
    wait_valid(lat, rdy_seen);
    check("sra_lat", 32'(lat), 32'd9);
    check("sra_rdy_low", 32'(rdy_seen), 32'd0);
    chk_res("sra", 32'hFFFFFFFF, 1'b0, 1'b0, 5'd7);
    tick();

    // Stream of 8 ops, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(vc[i], va[i], vb[i], 5'(i + 16));
      tick();
      check("strm_vld", 32'(out_valid), 32'd1);
      check("strm_res", out_result, ve[i]);
      check("strm_tag", 32'(out_tag), 32'(i + 16));
    end
    in_valid = 1'b0;
    tick();

    // Backpressure after SLL 1<<4; a waiting op must not be taken
    out_ready = 1'b0;
    issue(C_SLL, 32'h1, 32'd4, 5'd9);
    wait_valid(lat, rdy_seen);
    check("sll_lat", 32'(lat), 32'd2);
    drive(C_ADD, 32'd100, 32'd1, 5'd1);
    for (int i = 0; i < 3; i++) begin
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_res", out_result, 32'h10);
      check("bp_tag", 32'(out_tag), 32'd9);
      check("bp_rdy", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_res("bp_next", 32'd101, 1'b0, 1'b0, 5'd1);
    tick();
    check("bp_idle", 32'(out_valid), 32'd0);

    // Flush in second SHIFT cycle of SRL by 20
    issue(C_SRL, 32'hF0000000, 32'd20, 5'd11);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_vld", 32'(out_valid), 32'd0);
    check("fl_rdy", 32'(in_ready), 32'd1);
    check("fl_res_hold", out_result, 32'd101);
    check("fl_tag_hold", 32'(out_tag), 32'd1);
    vld_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) vld_seen = 1'b1;
      tick();
    end
    check("fl_never_vld", 32'(vld_seen), 32'd0);
    issue(C_ADD, 32'd2, 32'd3, 5'd12);
    chk_res("fl_after", 32'd5, 1'b0, 1'b0, 5'd12);
    tick();
    // Flush blocks an offered op
    flush = 1'b1;
    drive(C_ADD, 32'd7, 32'd8, 5'd13);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_noacc_vld", 32'(out_valid), 32'd0);
    check("fl_noacc_res", out_result, 32'd5);

    // Illegal again so out_illegal is 1 going into reset
    issue(4'b1111, 32'd1, 32'd1, 5'd20);
    chk_res("ill2", 32'd2, 1'b0, 1'b1, 5'd20);

    // Async reset in the middle of a shift
    issue(C_SRA, 32'h80000000, 32'd31, 5'd15);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("ar_vld", 32'(out_valid), 32'd0);
    check("ar_res", out_result, 32'd0);
    check("ar_ill", 32'(out_illegal), 32'd0);
    check("ar_tag", 32'(out_tag), 32'd0);
    check("ar_zero", 32'(out_zero), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("ar_rdy", 32'(in_ready), 32'd1);
    check("ar_vld2", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
